// File: rtl/sim_exit_monitor_pkg.sv
// Shared definitions for the end-of-test monitor: state encodings and byte geometry.
package sim_exit_monitor_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned BYTE_W  = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE            = 2'b00,
    ST_RUN             = 2'b01,
    ST_PASS            = 2'b10,
    ST_FAIL_OR_TIMEOUT = 2'b11
  } mon_state_e;

endpackage

// File: rtl/sim_exit_monitor_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/sim_exit_monitor.sv
// Snoops core stores, latches PASS/FAIL on signature writes, TIMEOUT after a RUN-cycle budget.
module sim_exit_monitor
  import sim_exit_monitor_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH     = 32,
  parameter int unsigned            DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0]  PASS_ADDR      = ADDR_WIDTH'(100),
  parameter logic [DATA_WIDTH-1:0]  PASS_DATA      = DATA_WIDTH'(25),
  parameter logic [ADDR_WIDTH-1:0]  FAIL_ADDR      = ADDR_WIDTH'(96),
  parameter int unsigned            TIMEOUT_CYCLES = 4700,
  parameter int unsigned            CNT_WIDTH      = 24
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic [DATA_WIDTH-1:0]        mem_wdata,
  input  logic [DATA_WIDTH/BYTE_W-1:0] mem_wmask,
  output logic                         done,
  output logic                         pass,
  output logic [STATE_W-1:0]           state,
  output logic                         timed_out,
  output logic [DATA_WIDTH-1:0]        fail_code,
  output logic [CNT_WIDTH-1:0]         cycle_count,
  output logic [CNT_WIDTH-1:0]         store_count
);

  localparam int unsigned NBYTES  = DATA_WIDTH / BYTE_W;
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam int unsigned TO_LAST = TO_EN ? (TIMEOUT_CYCLES - 1) : 0;

  mon_state_e             r_state;
  logic                   r_done;
  logic                   r_pass;
  logic                   r_timed_out;
  logic [DATA_WIDTH-1:0]  r_fail_code;

  logic                   w_run;
  logic                   w_store;
  logic                   w_pass_ok;
  logic                   w_pass_bad;
  logic                   w_fail_hit;
  logic                   w_timeout;
  logic [DATA_WIDTH-1:0]  w_masked_wdata;
  logic [CNT_WIDTH-1:0]   w_cycle_count;
  logic [CNT_WIDTH-1:0]   w_store_count;

  // Bus qualifiers; every term is gated by RUN so an undriven bus in IDLE stays inert.
  always_comb begin
    w_run      = (r_state == ST_RUN);
    w_store    = w_run && (|mem_wmask);
    w_pass_ok  = 1'b0;
    w_pass_bad = 1'b0;
    w_fail_hit = 1'b0;
    w_timeout  = 1'b0;
    if (w_store && (mem_addr == PASS_ADDR)) begin
      w_pass_ok  = (&mem_wmask) && (mem_wdata == PASS_DATA);
      w_pass_bad = !w_pass_ok;
    end
    if (w_store && (mem_addr == FAIL_ADDR)) begin
      w_fail_hit = 1'b1;
    end
    if (TO_EN && w_run && (w_cycle_count == CNT_WIDTH'(TO_LAST))) begin
      w_timeout = 1'b1;
    end
  end

  always_comb begin
    w_masked_wdata = '0;
    for (int b = 0; b < int'(NBYTES); b++) begin
      if (mem_wmask[b]) begin
        w_masked_wdata[b*BYTE_W +: BYTE_W] = mem_wdata[b*BYTE_W +: BYTE_W];
      end
    end
  end

  // State machine with registered terminal outputs; terminal states only exit via reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_timed_out <= 1'b0;
      r_fail_code <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_pass_ok) begin
            r_state <= ST_PASS;
            r_done  <= 1'b1;
            r_pass  <= 1'b1;
          end else if (w_pass_bad) begin
            r_state     <= ST_FAIL_OR_TIMEOUT;
            r_done      <= 1'b1;
            r_fail_code <= mem_wdata;
          end else if (w_fail_hit) begin
            r_state     <= ST_FAIL_OR_TIMEOUT;
            r_done      <= 1'b1;
            r_fail_code <= w_masked_wdata;
          end else if (w_timeout) begin
            r_state     <= ST_FAIL_OR_TIMEOUT;
            r_done      <= 1'b1;
            r_timed_out <= 1'b1;
            r_fail_code <= {DATA_WIDTH{1'b1}};
          end
        end
        default: begin
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_run),
    .count (w_cycle_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_store_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_store),
    .count (w_store_count)
  );

  assign state       = r_state;
  assign done        = r_done;
  assign pass        = r_pass;
  assign timed_out   = r_timed_out;
  assign fail_code   = r_fail_code;
  assign cycle_count = w_cycle_count;
  assign store_count = w_store_count;

endmodule

// File: tb/tb_sim_exit_monitor.sv
// Directed bench for sim_exit_monitor: a default instance, a 50-cycle-timeout instance and a 4-bit-counter instance share one bus.
module tb_sim_exit_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;

  logic        d0_done, d0_pass, d0_to;
  logic [1:0]  d0_state;
  logic [31:0] d0_fc;
  logic [23:0] d0_cc, d0_sc;

  logic        d1_done, d1_pass, d1_to;
  logic [1:0]  d1_state;
  logic [31:0] d1_fc;
  logic [23:0] d1_cc, d1_sc;

  logic        d2_done, d2_pass, d2_to;
  logic [1:0]  d2_state;
  logic [31:0] d2_fc;
  logic [3:0]  d2_cc, d2_sc;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [1:0]  st;
    logic        ps;
    logic [31:0] fc;
    logic [23:0] sc;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  sim_exit_monitor dut (
    .clk(clk), .reset(reset), .enable(enable),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .done(d0_done), .pass(d0_pass), .state(d0_state), .timed_out(d0_to),
    .fail_code(d0_fc), .cycle_count(d0_cc), .store_count(d0_sc)
  );

  sim_exit_monitor #(.TIMEOUT_CYCLES(50)) dut_to (
    .clk(clk), .reset(reset), .enable(enable),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .done(d1_done), .pass(d1_pass), .state(d1_state), .timed_out(d1_to),
    .fail_code(d1_fc), .cycle_count(d1_cc), .store_count(d1_sc)
  );

  sim_exit_monitor #(.TIMEOUT_CYCLES(0), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .reset(reset), .enable(enable),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .done(d2_done), .pass(d2_pass), .state(d2_state), .timed_out(d2_to),
    .fail_code(d2_fc), .cycle_count(d2_cc), .store_count(d2_sc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic bus_idle();
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_wmask = 4'h0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    mem_addr  = a;
    mem_wdata = d;
    mem_wmask = m;
    tick();
    bus_idle();
  endtask

  // Reset, arm for one cycle, then drop enable; leaves the monitors in RUN with cycle_count 0.
  task automatic start_run();
    reset  = 1'b1;
    enable = 1'b0;
    bus_idle();
    tick();
    tick();
    reset  = 1'b0;
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    bus_idle();

    vecs[0] = '{32'd100,        32'd25,         4'hF, 2'b10, 1'b1, 32'd0,         24'd1};
    vecs[1] = '{32'd100,        32'd24,         4'hF, 2'b11, 1'b0, 32'd24,        24'd1};
    vecs[2] = '{32'd100,        32'd25,         4'h3, 2'b11, 1'b0, 32'd25,        24'd1};
    vecs[3] = '{32'd96,         32'hDEAD_BEEF,  4'hF, 2'b11, 1'b0, 32'hDEAD_BEEF, 24'd1};
    vecs[4] = '{32'd96,         32'hDEAD_BEEF,  4'h5, 2'b11, 1'b0, 32'h00AD_00EF, 24'd1};
    vecs[5] = '{32'd200,        32'd25,         4'hF, 2'b01, 1'b0, 32'd0,         24'd1};
    vecs[6] = '{32'd101,        32'd25,         4'hF, 2'b01, 1'b0, 32'd0,         24'd1};
    vecs[7] = '{32'd100,        32'd25,         4'h0, 2'b01, 1'b0, 32'd0,         24'd0};
    vecs[8] = '{32'h8000_0064,  32'd25,         4'hF, 2'b01, 1'b0, 32'd0,         24'd1};
    vecs[9] = '{32'd96,         32'd0,          4'h1, 2'b11, 1'b0, 32'd0,         24'd1};

    // Reset state of every instance.
    tick();
    tick();
    chk("rst state",   64'(d0_state), 64'd0);
    chk("rst done",    64'(d0_done),  64'd0);
    chk("rst pass",    64'(d0_pass),  64'd0);
    chk("rst to",      64'(d0_to),    64'd0);
    chk("rst fc",      64'(d0_fc),    64'd0);
    chk("rst cc",      64'(d0_cc),    64'd0);
    chk("rst sc",      64'(d0_sc),    64'd0);
    chk("rst to state", 64'(d1_state), 64'd0);
    chk("rst sat sc",  64'(d2_sc),    64'd0);

    // IDLE for 5 cycles with a pass signature on the bus: must be ignored.
    reset     = 1'b0;
    mem_addr  = 32'd100;
    mem_wdata = 32'd25;
    mem_wmask = 4'hF;
    repeat (5) tick();
    chk("idle state", 64'(d0_state), 64'd0);
    chk("idle cc",    64'(d0_cc),    64'd0);
    chk("idle sc",    64'(d0_sc),    64'd0);
    chk("idle done",  64'(d0_done),  64'd0);
    bus_idle();
    enable = 1'b1;
    tick();
    chk("armed state", 64'(d0_state), 64'd1);
    chk("armed cc",    64'(d0_cc),    64'd0);
    repeat (3) tick();
    enable = 1'b0;
    repeat (37) tick();
    chk("run40 cc", 64'(d0_cc), 64'd40);
    store(32'd100, 32'd25, 4'hF);
    chk("pass done",  64'(d0_done),  64'd1);
    chk("pass pass",  64'(d0_pass),  64'd1);
    chk("pass state", 64'(d0_state), 64'd2);
    chk("pass cc",    64'(d0_cc),    64'd41);
    chk("pass sc",    64'(d0_sc),    64'd1);
    chk("pass to",    64'(d0_to),    64'd0);
    chk("sat pass state", 64'(d2_state), 64'd2);
    chk("sat pass cc",    64'(d2_cc),    64'd15);
    repeat (5) tick();
    store(32'd96, 32'h1111_2222, 4'hF);
    chk("sticky state", 64'(d0_state), 64'd2);
    chk("sticky cc",    64'(d0_cc),    64'd41);
    chk("sticky sc",    64'(d0_sc),    64'd1);
    chk("sticky fc",    64'(d0_fc),    64'd0);

    // Table of single-store outcomes, each after 3 quiet RUN cycles.
    for (int i = 0; i < 10; i++) begin
      start_run();
      repeat (3) tick();
      chk($sformatf("v%0d pre state", i), 64'(d0_state), 64'd1);
      store(vecs[i].addr, vecs[i].data, vecs[i].mask);
      chk($sformatf("v%0d state", i), 64'(d0_state), 64'(vecs[i].st));
      chk($sformatf("v%0d done", i),  64'(d0_done),  64'(vecs[i].st[1]));
      chk($sformatf("v%0d pass", i),  64'(d0_pass),  64'(vecs[i].ps));
      chk($sformatf("v%0d to", i),    64'(d0_to),    64'd0);
      chk($sformatf("v%0d fc", i),    64'(d0_fc),    64'(vecs[i].fc));
      chk($sformatf("v%0d cc", i),    64'(d0_cc),    64'd4);
      chk($sformatf("v%0d sc", i),    64'(d0_sc),    64'(vecs[i].sc));
    end

    // FAIL is sticky against a later pass signature.
    start_run();
    store(32'd96, 32'hDEAD_BEEF, 4'hF);
    store(32'd100, 32'd25, 4'hF);
    tick();
    chk("failstk state", 64'(d0_state), 64'd3);
    chk("failstk fc",    64'(d0_fc),    64'hDEAD_BEEF);
    chk("failstk pass",  64'(d0_pass),  64'd0);
    chk("failstk sc",    64'(d0_sc),    64'd1);
    chk("failstk cc",    64'(d0_cc),    64'd1);

    // Timeout after exactly 50 RUN cycles.
    start_run();
    repeat (49) tick();
    chk("to49 state", 64'(d1_state), 64'd1);
    chk("to49 cc",    64'(d1_cc),    64'd49);
    chk("to49 done",  64'(d1_done),  64'd0);
    tick();
    chk("to state", 64'(d1_state), 64'd3);
    chk("to done",  64'(d1_done),  64'd1);
    chk("to flag",  64'(d1_to),    64'd1);
    chk("to pass",  64'(d1_pass),  64'd0);
    chk("to fc",    64'(d1_fc),    64'hFFFF_FFFF);
    chk("to cc",    64'(d1_cc),    64'd50);
    chk("to sc",    64'(d1_sc),    64'd0);
    repeat (5) tick();
    chk("to frozen cc", 64'(d1_cc),    64'd50);
    chk("def no to",    64'(d0_state), 64'd1);
    chk("def cc55",     64'(d0_cc),    64'd55);
    chk("sat no to",    64'(d2_state), 64'd1);

    // Signature store on the expiring cycle beats the timeout.
    start_run();
    repeat (49) tick();
    store(32'd100, 32'd25, 4'hF);
    chk("to49 pass state", 64'(d1_state), 64'd2);
    chk("to49 pass to",    64'(d1_to),    64'd0);
    chk("to49 pass cc",    64'(d1_cc),    64'd50);
    start_run();
    repeat (49) tick();
    store(32'd96, 32'h0000_1234, 4'hF);
    chk("to49 fail state", 64'(d1_state), 64'd3);
    chk("to49 fail to",    64'(d1_to),    64'd0);
    chk("to49 fail fc",    64'(d1_fc),    64'h1234);

    // Mid-run reset after 10 stores, then a clean second run.
    start_run();
    for (int i = 0; i < 10; i++) store(32'd200, 32'(i), 4'hF);
    chk("mid sc", 64'(d0_sc), 64'd10);
    chk("mid cc", 64'(d0_cc), 64'd10);
    reset = 1'b1;
    tick();
    chk("mid rst state", 64'(d0_state), 64'd0);
    chk("mid rst sc",    64'(d0_sc),    64'd0);
    chk("mid rst cc",    64'(d0_cc),    64'd0);
    reset  = 1'b0;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    chk("rerun state", 64'(d0_state), 64'd1);
    chk("rerun sc",    64'(d0_sc),    64'd0);
    store(32'd100, 32'd25, 4'hF);
    chk("rerun pass", 64'(d0_pass), 64'd1);
    chk("rerun sc1",  64'(d0_sc),   64'd1);
    chk("rerun cc1",  64'(d0_cc),   64'd1);

    // 4-bit counters saturate under 20 non-signature stores.
    start_run();
    for (int i = 0; i < 20; i++) store(32'd200, 32'hA5A5_0000 | 32'(i), 4'hF);
    chk("sat sc",    64'(d2_sc),    64'd15);
    chk("sat cc",    64'(d2_cc),    64'd15);
    chk("sat state", 64'(d2_state), 64'd1);
    chk("sat done",  64'(d2_done),  64'd0);
    chk("sat to",    64'(d2_to),    64'd0);
    chk("sat fc",    64'(d2_fc),    64'd0);
    chk("def sc20",  64'(d0_sc),    64'd20);
    chk("to sc20",   64'(d1_sc),    64'd20);
    chk("to pass20", 64'(d1_pass),  64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
